// File: rtl/ws2812_frame_controller_pkg.sv
// Shared types and default timing for the WS2812 receive pipeline.
package ws2812_frame_controller_pkg;
    localparam int COUNT_WIDTH    = 10;   // counter MSB is the saturation flag
    localparam int PIXEL_BITS     = 24;
    localparam int BIT1_MIN_TICKS = 6;
    localparam int HIGH_MAX_TICKS = 12;
    localparam int RESET_TICKS    = 500;

    typedef struct packed {
        logic rising;
        logic falling;
    } control_path_t;

    typedef struct packed {
        logic [COUNT_WIDTH-1:0] counter;
    } decoder_input_t;

    typedef enum logic [1:0] {S_SYNC, S_IDLE, S_CAPTURE, S_FORWARD} frame_state_e;

    typedef struct packed {
        logic [7:0] g;
        logic [7:0] r;
        logic [7:0] b;
    } pixel_t;

    typedef struct packed {
        logic pixel_valid;
        logic forward_en;
        logic frame_done;
        logic bit_error;
    } frame_status_t;
endpackage

// File: rtl/ws2812_frame_controller_if.sv
// Line-side inputs and pixel/status outputs of the frame controller.
interface ws2812_frame_controller_if;
    import ws2812_frame_controller_pkg::*;

    control_path_t  i_control;
    decoder_input_t i_decoder_input;
    logic           i_din;
    pixel_t         o_pixel;
    logic           o_pixel_valid;
    logic           o_forward_en;
    logic           o_frame_done;
    logic           o_bit_error;

    modport master (
        output i_control, i_decoder_input, i_din,
        input  o_pixel, o_pixel_valid, o_forward_en, o_frame_done, o_bit_error
    );

    modport slave (
        input  i_control, i_decoder_input, i_din,
        output o_pixel, o_pixel_valid, o_forward_en, o_frame_done, o_bit_error
    );
endinterface

// File: rtl/ws2812_bit_classifier.sv
// Compares a sampled high time against the 0/1 and malformed thresholds.
module ws2812_bit_classifier
    import ws2812_frame_controller_pkg::*;
#(
    parameter int BIT1_MIN_TICKS = ws2812_frame_controller_pkg::BIT1_MIN_TICKS,
    parameter int HIGH_MAX_TICKS = ws2812_frame_controller_pkg::HIGH_MAX_TICKS
) (
    input  logic [COUNT_WIDTH-1:0] high_ticks,
    output logic                   bit_o,
    output logic                   err_o
);
    localparam logic [COUNT_WIDTH-1:0] BIT1_TH = COUNT_WIDTH'(BIT1_MIN_TICKS);
    localparam logic [COUNT_WIDTH-1:0] ERR_TH  = COUNT_WIDTH'(HIGH_MAX_TICKS);

    // Left unregistered so the last bit lands in o_pixel on the very next edge;
    // the top registers the result together with the shift register.
    assign bit_o = (high_ticks >= BIT1_TH);
    assign err_o = (high_ticks >= ERR_TH);
endmodule

// File: rtl/ws2812_frame_controller.sv
// WS2812 frame sequencer: gap detection, 24-bit pixel capture, pass-through control.
module ws2812_frame_controller
    import ws2812_frame_controller_pkg::*;
#(
    parameter int BIT1_MIN_TICKS = ws2812_frame_controller_pkg::BIT1_MIN_TICKS,
    parameter int HIGH_MAX_TICKS = ws2812_frame_controller_pkg::HIGH_MAX_TICKS,
    parameter int RESET_TICKS    = ws2812_frame_controller_pkg::RESET_TICKS
) (
    input  logic                       i_clk,
    input  logic                       i_reset_n,
    ws2812_frame_controller_if.slave   bus
);
    localparam int                     IDX_W    = $clog2(PIXEL_BITS + 1);
    localparam logic [IDX_W-1:0]       LAST_IDX = IDX_W'(PIXEL_BITS - 1);
    localparam logic [COUNT_WIDTH-1:0] RESET_TH = COUNT_WIDTH'(RESET_TICKS);

    frame_state_e            state_q, state_n;
    logic [PIXEL_BITS-1:0]   shift_q, shift_n;
    logic [IDX_W-1:0]        idx_q, idx_n;
    pixel_t                  pixel_q, pixel_n;
    frame_status_t           stat_q, stat_n;
    logic                    fall, gap, cls_bit, cls_err;

    assign fall = bus.i_control.falling;
    assign gap  = !bus.i_din && !bus.i_control.rising && !bus.i_control.falling &&
                  (bus.i_decoder_input.counter >= RESET_TH);

    ws2812_bit_classifier #(
        .BIT1_MIN_TICKS (BIT1_MIN_TICKS),
        .HIGH_MAX_TICKS (HIGH_MAX_TICKS)
    ) u_cls (
        .high_ticks (bus.i_decoder_input.counter),
        .bit_o      (cls_bit),
        .err_o      (cls_err)
    );

    always_comb begin
        state_n           = state_q;
        shift_n           = shift_q;
        idx_n             = idx_q;
        pixel_n           = pixel_q;
        stat_n            = '0;
        stat_n.forward_en = stat_q.forward_en;
        // A malformed pulse outside S_SYNC aborts whatever frame is in flight.
        if (state_q != S_SYNC && fall && cls_err) begin
            stat_n.bit_error  = 1'b1;
            stat_n.forward_en = 1'b0;
            shift_n           = '0;
            idx_n             = '0;
            state_n           = S_SYNC;
        end else begin
            case (state_q)
                S_SYNC: if (gap) state_n = S_IDLE;
                S_IDLE: if (fall) begin
                    shift_n = {{(PIXEL_BITS-1){1'b0}}, cls_bit};
                    idx_n   = IDX_W'(1);
                    state_n = S_CAPTURE;
                end
                S_CAPTURE: if (fall) begin
                    shift_n = {shift_q[PIXEL_BITS-2:0], cls_bit};
                    idx_n   = idx_q + 1'b1;
                    if (idx_q == LAST_IDX) begin
                        pixel_n            = {shift_q[PIXEL_BITS-2:0], cls_bit};
                        stat_n.pixel_valid = 1'b1;
                        stat_n.forward_en  = 1'b1;
                        shift_n            = '0;
                        idx_n              = '0;
                        state_n            = S_FORWARD;
                    end
                end else if (gap) begin
                    shift_n           = '0;
                    idx_n             = '0;
                    stat_n.frame_done = 1'b1;
                    state_n           = S_IDLE;
                end
                S_FORWARD: if (gap) begin
                    stat_n.forward_en = 1'b0;
                    stat_n.frame_done = 1'b1;
                    state_n           = S_IDLE;
                end
                default: state_n = S_SYNC;
            endcase
        end
    end

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            state_q <= S_SYNC;
            shift_q <= '0;
            idx_q   <= '0;
            pixel_q <= '0;
            stat_q  <= '0;
        end else begin
            state_q <= state_n;
            shift_q <= shift_n;
            idx_q   <= idx_n;
            pixel_q <= pixel_n;
            stat_q  <= stat_n;
        end
    end

    assign bus.o_pixel       = pixel_q;
    assign bus.o_pixel_valid = stat_q.pixel_valid;
    assign bus.o_forward_en  = stat_q.forward_en;
    assign bus.o_frame_done  = stat_q.frame_done;
    assign bus.o_bit_error   = stat_q.bit_error;
endmodule

// File: tb/tb_ws2812_frame_controller.sv
// Directed line-level stimulus with an event scoreboard for pixel/frame/error pulses.
module tb_ws2812_frame_controller;
    localparam int EV_PV = 1;
    localparam int EV_FD = 2;
    localparam int EV_BE = 3;

    typedef struct {
        int          kind;
        logic [23:0] pix;
        int          cyc;
    } ev_t;

    logic clk;
    logic rst_n;
    int   cyc = 0;
    int   total = 0;
    int   bad = 0;
    int   cnt = 0;
    logic prev_din = 1'b0;
    ev_t  exp_q[$];

    ws2812_frame_controller_if bus();

    ws2812_frame_controller dut (
        .i_clk     (clk),
        .i_reset_n (rst_n),
        .bus       (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", name, got, exp);
        end
    endtask

    // Monitor: every output pulse must match the head of the expected-event queue.
    always @(negedge clk) begin
        int  k;
        ev_t e;
        if (exp_q.size() > 0 && exp_q[0].cyc < cyc) begin
            total++;
            bad++;
            $display("FAIL missed_event got=none exp=kind%0d@%0d", exp_q[0].kind, exp_q[0].cyc);
            void'(exp_q.pop_front());
        end
        k = bus.o_pixel_valid ? EV_PV : bus.o_frame_done ? EV_FD : bus.o_bit_error ? EV_BE : 0;
        if (k != 0) begin
            total++;
            if (exp_q.size() == 0) begin
                bad++;
                $display("FAIL unexpected_event got=kind%0d@%0d exp=none", k, cyc);
            end else begin
                e = exp_q.pop_front();
                if (e.kind != k || e.cyc != cyc ||
                    (bus.o_pixel_valid + bus.o_frame_done + bus.o_bit_error) != 2'd1 ||
                    (k == EV_PV && bus.o_pixel !== e.pix)) begin
                    bad++;
                    $display("FAIL event got=kind%0d@%0d pix=%0h exp=kind%0d@%0d pix=%0h",
                             k, cyc, bus.o_pixel, e.kind, e.cyc, e.pix);
                end
            end
        end
    end

    // One line cycle; the edge cycle shows the pre-clear tick count of the previous level.
    task automatic step(input logic din, input int kind, input logic [23:0] pix);
        logic       r, f;
        logic [9:0] c;
        r = din && !prev_din;
        f = !din && prev_din;
        c = (cnt > 512) ? 10'd512 : cnt[9:0];
        if (kind != 0) exp_q.push_back('{kind: kind, pix: pix, cyc: cyc + 1});
        bus.i_din                   = din;
        bus.i_control.rising        = r;
        bus.i_control.falling       = f;
        bus.i_decoder_input.counter = c;
        @(posedge clk);
        #1;
        cnt      = (r || f) ? 1 : cnt + 1;
        prev_din = din;
    endtask

    task automatic send_bit(input int h, input int kind, input logic [23:0] pix);
        repeat (h) step(1'b1, 0, 24'h0);
        step(1'b0, kind, pix);
        repeat (3) step(1'b0, 0, 24'h0);
    endtask

    task automatic send_bits(input logic [23:0] px, input int n, input int kind_last);
        for (int i = 0; i < n; i++)
            send_bit(px[23-i] ? 8 : 3, (i == n - 1) ? kind_last : 0, px);
    endtask

    // Hold the line low until the shown count reaches t; flag the first gap cycle if asked.
    task automatic low_ticks(input int t, input bit exp_done);
        bit pushed;
        int k;
        pushed = 1'b0;
        while (cnt <= t) begin
            k = 0;
            if (exp_done && !pushed && !prev_din && cnt >= 500) begin
                k      = EV_FD;
                pushed = 1'b1;
            end
            step(1'b0, k, 24'h0);
        end
    endtask

    initial begin
        int htab[24];
        htab = '{5,6,11,5,6,11,5,6, 5,6,11,5,6,11,5,6, 5,6,11,5,6,11,5,6};
        bus.i_din                   = 1'b0;
        bus.i_control               = '0;
        bus.i_decoder_input.counter = '0;
        rst_n = 1'b1;
        #1 rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("reset_outputs", {4'h0, bus.o_pixel, bus.o_pixel_valid, bus.o_forward_en,
                              bus.o_frame_done, bus.o_bit_error}, 32'h0);
        rst_n = 1'b1;

        // First frame after power-up gap
        low_ticks(520, 1'b0);
        send_bits(24'hA5C3F0, 24, EV_PV);
        chk("fwd_after_capture", {31'h0, bus.o_forward_en}, 32'h1);
        chk("pixel_first", {8'h0, bus.o_pixel}, 32'h00A5C3F0);
        send_bits(24'h123456, 24, 0);
        send_bits(24'hFEDCBA, 24, 0);
        chk("fwd_held", {31'h0, bus.o_forward_en}, 32'h1);
        chk("pixel_held", {8'h0, bus.o_pixel}, 32'h00A5C3F0);
        low_ticks(520, 1'b1);
        chk("fwd_cleared", {31'h0, bus.o_forward_en}, 32'h0);

        // Malformed 10th bit, then a frame ignored until a gap
        send_bits(24'hFFFFFF, 9, 0);
        send_bit(14, EV_BE, 24'h0);
        chk("fwd_after_err", {31'h0, bus.o_forward_en}, 32'h0);
        send_bits(24'h123456, 24, 0);
        low_ticks(520, 1'b0);
        send_bits(24'h0F1E2D, 24, EV_PV);
        chk("pixel_after_err", {8'h0, bus.o_pixel}, 32'h000F1E2D);
        low_ticks(520, 1'b1);

        // Short frame, then threshold-boundary frame ending on an exact 500-tick gap
        send_bits(24'hABCDEF, 12, 0);
        low_ticks(520, 1'b1);
        chk("pixel_after_short", {8'h0, bus.o_pixel}, 32'h000F1E2D);
        for (int i = 0; i < 24; i++)
            send_bit(htab[i], (i == 23) ? EV_PV : 0, 24'h6D6D6D);
        chk("pixel_boundary", {8'h0, bus.o_pixel}, 32'h006D6D6D);
        low_ticks(500, 1'b1);
        chk("fwd_after_gap500", {31'h0, bus.o_forward_en}, 32'h0);

        // H=12 error; 499-tick low must not resync, 500 must
        send_bit(12, EV_BE, 24'h0);
        low_ticks(499, 1'b0);
        send_bits(24'hFFFFFF, 24, 0);
        chk("pixel_no_resync", {8'h0, bus.o_pixel}, 32'h006D6D6D);
        low_ticks(500, 1'b0);
        send_bits(24'h00FF00, 24, EV_PV);
        chk("pixel_resync", {8'h0, bus.o_pixel}, 32'h0000FF00);
        low_ticks(520, 1'b1);

        // Reset during bit 20
        send_bits(24'h3C3C3C, 19, 0);
        repeat (4) step(1'b1, 0, 24'h0);
        rst_n = 1'b0;
        #1;
        chk("midreset_outputs", {4'h0, bus.o_pixel, bus.o_pixel_valid, bus.o_forward_en,
                                 bus.o_frame_done, bus.o_bit_error}, 32'h0);
        repeat (2) step(1'b1, 0, 24'h0);
        rst_n = 1'b1;
        repeat (2) step(1'b1, 0, 24'h0);
        repeat (4) step(1'b0, 0, 24'h0);
        send_bits(24'h3C3C3C, 4, 0);
        send_bits(24'hA5A5A5, 24, 0);
        chk("pixel_after_reset", {8'h0, bus.o_pixel}, 32'h0);
        low_ticks(500, 1'b0);
        send_bits(24'hC0FFEE, 24, EV_PV);
        chk("pixel_final", {8'h0, bus.o_pixel}, 32'h00C0FFEE);
        low_ticks(520, 1'b1);
        chk("fwd_final", {31'h0, bus.o_forward_en}, 32'h0);

        repeat (4) step(1'b0, 0, 24'h0);
        chk("queue_drained", exp_q.size(), 32'h0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
